// File: rtl/jac_pkg.sv
// Shared constants and types for the fetch stage: datapath widths, opcode map,
// NOP encoding and the fetch FSM state type.
package jac_pkg;

    localparam int PC_WIDTH          = 8;
    localparam int PROGRAM_DataWidth = 16;

    // Opcode lives in the top five bits of the instruction word.
    localparam int OPCODE_WIDTH = 5;
    localparam logic [OPCODE_WIDTH-1:0] OP_NOP   = 5'h00;
    localparam logic [OPCODE_WIDTH-1:0] OP_LOAD  = 5'h01;
    localparam logic [OPCODE_WIDTH-1:0] OP_STORE = 5'h02;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD   = 5'h03;
    localparam logic [OPCODE_WIDTH-1:0] OP_JMP   = 5'h04;
    localparam logic [OPCODE_WIDTH-1:0] OP_BRA   = 5'h05;

    localparam logic [PROGRAM_DataWidth-1:0] NOP = 16'h0000;

    // Fetch cycles without ack tolerated before the timeout fires (16th cycle).
    localparam logic [3:0] FETCH_TIMEOUT_LAST = 4'hF;

    typedef logic [1:0] fsm_state_t;
    localparam fsm_state_t ST_IDLE  = 2'd0;
    localparam fsm_state_t ST_FETCH = 2'd1;
    localparam fsm_state_t ST_EXEC  = 2'd2;

    function automatic logic [OPCODE_WIDTH-1:0] opcode_of(
        input logic [PROGRAM_DataWidth-1:0] instr
    );
        return instr[PROGRAM_DataWidth-1 -: OPCODE_WIDTH];
    endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Next program-counter arithmetic: absolute load, PC-relative branch
// (offset taken from the branch's own address) or sequential increment.
module pc_next_calc #(
    parameter int PC_WIDTH = 8
) (
    input  logic [PC_WIDTH-1:0] pc,
    input  logic                cnt_wr_en,
    input  logic                add_offset,
    input  logic [PC_WIDTH-1:0] literal_adr,
    output logic [PC_WIDTH-1:0] next_pc
);

    always_comb begin
        next_pc = pc + PC_WIDTH'(1);
        if (cnt_wr_en) begin
            // Offset already spans the full PC width, so two's-complement
            // addition with truncation gives the signed, wrapping result.
            if (add_offset) begin
                next_pc = pc + literal_adr;
            end else begin
                next_pc = literal_adr;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: IDLE/FETCH/EXEC sequencer, PC and instruction register.
// Optional fetch timeout with sticky fetch_err is built when FETCH_TIMEOUT_EN is defined.
module fetch_unit #(
    parameter int                PC_WIDTH          = jac_pkg::PC_WIDTH,
    parameter int                PROGRAM_DataWidth = jac_pkg::PROGRAM_DataWidth,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR    = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    output logic [PC_WIDTH-1:0]          imem_addr,
    output logic                         imem_req,
    input  logic                         imem_ack,
    input  logic [PROGRAM_DataWidth-1:0] imem_data,
    output logic [PROGRAM_DataWidth-1:0] instruction,
    output logic                         instr_valid,
    input  logic                         stall,
    input  logic                         cnt_wr_en,
    input  logic                         add_offset,
    input  logic [PC_WIDTH-1:0]          literal_adr,
    output logic [PC_WIDTH-1:0]          pc,
    output logic                         fetch_err,
    output logic [1:0]                   state_dbg
);

    import jac_pkg::*;

    // Memory handshake: imem_req is high for every FETCH cycle; the word is
    // accepted on the first FETCH cycle that sees imem_ack high, and ack in
    // any other state is ignored.

    fsm_state_t                   state_d, state_q;
    logic [PC_WIDTH-1:0]          pc_d, pc_q;
    logic [PROGRAM_DataWidth-1:0] instr_d, instr_q;
    logic [PC_WIDTH-1:0]          pc_next;
    logic                         fetch_timeout;

    pc_next_calc #(
        .PC_WIDTH (PC_WIDTH)
    ) u_pc_next_calc (
        .pc          (pc_q),
        .cnt_wr_en   (cnt_wr_en),
        .add_offset  (add_offset),
        .literal_adr (literal_adr),
        .next_pc     (pc_next)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_data;
                    state_d = ST_EXEC;
                end else if (fetch_timeout) begin
                    instr_d = PROGRAM_DataWidth'(NOP);
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!stall) begin
                    pc_d    = pc_next;
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_VECTOR;
            instr_q <= PROGRAM_DataWidth'(NOP);
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    logic [3:0] to_cnt_d, to_cnt_q;
    logic       fetch_err_d, fetch_err_q;

    always_comb begin
        to_cnt_d = '0;
        if ((state_q == ST_FETCH) && !imem_ack) begin
            to_cnt_d = to_cnt_q + 4'd1;
        end
    end

    assign fetch_timeout = (state_q == ST_FETCH) && !imem_ack
                           && (to_cnt_q == FETCH_TIMEOUT_LAST);
    assign fetch_err_d   = fetch_err_q | fetch_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q    <= '0;
            fetch_err_q <= 1'b0;
        end else begin
            to_cnt_q    <= to_cnt_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    assign fetch_err = fetch_err_q;
`else
    assign fetch_timeout = 1'b0;
    assign fetch_err     = 1'b0;
`endif

    // Outputs decode straight from state so an async reset drops imem_req at once.
    assign imem_req    = (state_q == ST_FETCH);
    assign instr_valid = (state_q == ST_EXEC);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instruction = instr_q;
    assign state_dbg   = state_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_WIDTH, default 8: program-counter and program-memory address width.
REQ-002 Parameter PROGRAM_DataWidth, default 16: instruction word width.
REQ-003 Parameter RESET_VECTOR, default 8'h00: PC value loaded on reset.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 imem_addr  out  PC_WIDTH  program-memory address; equals pc.
REQ-008 imem_req  out  1  fetch request to program memory.
REQ-009 imem_ack  in  1  memory data valid; sampled only in FETCH.
REQ-010 imem_data  in  PROGRAM_DataWidth  instruction word, valid with imem_ack.
REQ-011 instruction  out  PROGRAM_DataWidth  instruction register driving the decoder.
REQ-012 instr_valid  out  1  high while instruction is in execute.
REQ-013 stall  in  1  holds execute; PC and instruction frozen.
REQ-014 cnt_wr_en  in  1  decoder: PC load request.
REQ-015 add_offset  in  1  decoder: 1 = relative jump, 0 = absolute jump.
REQ-016 literal_adr  in  PC_WIDTH  decoder: jump target or signed offset.
REQ-017 pc  out  PC_WIDTH  address of the instruction currently held.
REQ-018 fetch_err  out  1  sticky fetch-timeout flag.

Function
REQ-019 The FSM SHALL have states IDLE, FETCH and EXEC.
REQ-020 IDLE: imem_req=0; go to FETCH on the next edge.
REQ-021 FETCH: imem_req=1; on imem_ack=1, load imem_data into instruction and go to EXEC. Without ack, stay in FETCH.
REQ-022 EXEC: instr_valid=1 and imem_req=0.
REQ-023 EXEC with stall=1: hold EXEC with pc and instruction unchanged.
REQ-024 EXEC with stall=0: update pc per REQ-025..027 and go to FETCH.
REQ-025 Next PC when cnt_wr_en=1 and add_offset=0: pc <= literal_adr.
REQ-026 Next PC when cnt_wr_en=1 and add_offset=1: pc <= pc + sign-extended literal_adr, modulo 2^PC_WIDTH. The offset is relative to the branch instruction's own address.
REQ-027 Next PC when cnt_wr_en=0: pc <= pc + 1; 8'hFF wraps to 8'h00.
REQ-028 cnt_wr_en, add_offset and literal_adr SHALL be ignored outside EXEC.
REQ-029 imem_ack outside FETCH SHALL be ignored and SHALL NOT alter instruction.
REQ-030 Minimum cycle is 1 FETCH cycle (ack in the same cycle) plus 1 EXEC cycle, i.e. one instruction per 2 clocks.
REQ-031 The instruction register SHALL be written only on a FETCH-state ack.

Reset
REQ-032 Reset values: pc=RESET_VECTOR, instruction=16'h0000 (NOP), instr_valid=0, imem_req=0, fetch_err=0, state=IDLE.
REQ-033 Reset asserted mid-FETCH or mid-EXEC SHALL abort immediately; imem_req drops without waiting for a clock edge.

Configuration
REQ-034 Macro FETCH_TIMEOUT_EN defined: a 4-bit counter counts FETCH cycles without ack.
REQ-035 On the 16th such cycle: instruction <= 16'h0000, fetch_err <= 1 (sticky until reset), go to EXEC.
REQ-036 Macro FETCH_TIMEOUT_EN undefined: FETCH waits indefinitely, fetch_err is tied 0, and no counter is built.

Structure
REQ-037 Shared package jac_pkg SHALL hold the PC_WIDTH and PROGRAM_DataWidth constants, the opcode constants, the NOP encoding and the FSM state typedef.
REQ-038 Next-PC arithmetic (REQ-025..027) SHALL be a combinational sub-module named pc_next_calc; the FSM, registers and timeout counter stay in fetch_unit.

Verification
REQ-039 Scenario, sequential fetch: reset, then ack each FETCH with data 16'h0800, cnt_wr_en=0 -> imem_addr sequence 00,01,02; instr_valid high every 2nd cycle.
REQ-040 Scenario, absolute jump: at pc=05, cnt_wr_en=1, add_offset=0, literal_adr=8'h3F -> next imem_addr=3F.
REQ-041 Scenario, relative jump with wrap: at pc=02, add_offset=1, literal_adr=8'hFC (-4) -> next pc=FE; at pc=FF with no jump -> next pc=00.
REQ-042 Scenario, stall: stall=1 for 3 EXEC cycles -> pc, instruction and instr_valid constant; imem_req=0; resumes on release.
REQ-043 Scenario, timeout: imem_ack held 0 with FETCH_TIMEOUT_EN -> after 16 cycles instruction=0000 and fetch_err=1; without the macro, still FETCH after 100 cycles.
REQ-044 Scenario, reset mid-FETCH: rst_n low mid-FETCH -> imem_req=0 immediately and pc=RESET_VECTOR; a late imem_ack is ignored.
